// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and constants for the counter-based synchronous FIFO and the
// blocks that attach to it.
//   FIFO_DATA_WIDTH   : default data word width
//   ADAPTER_BUF_DEPTH : depth of the read-stream adapter output buffer
//   data_t            : one data word at the default width
//   ptr3_t            : pointer into the 3-entry adapter buffer
//   ptr3_next()       : pointer increment with explicit 2 -> 0 wrap
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH   = 8;
  localparam int ADAPTER_BUF_DEPTH = 3;

  typedef logic [FIFO_DATA_WIDTH-1:0] data_t;
  typedef logic [1:0]                 ptr3_t;

  // Depth 3 is not a power of two, so the wrap has to be explicit.
  function automatic ptr3_t ptr3_next(input ptr3_t p);
    ptr3_t n;
    if (p == 2'd2) begin
      n = 2'd0;
    end else begin
      n = p + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_skid_buf3.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf3
// Three-entry circular output buffer for the FIFO read-stream adapter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i into the tail slot
//   push_data_i  : word to store
//   pop_i        : consumer took the head word (ignored when empty)
//   valid_o      : buffer holds at least one word
//   data_o       : head word, zero when empty
//   cnt_o        : number of stored words (0..3)
// -----------------------------------------------------------------------------
module fifo_skid_buf3
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            cnt_o
);

  logic [DATA_WIDTH-1:0] mem_q [ADAPTER_BUF_DEPTH];
  ptr3_t                 head_q, head_d;
  ptr3_t                 tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pop_s;

  assign pop_s   = pop_i && (cnt_q != 2'd0);
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = (cnt_q != 2'd0) ? mem_q[head_q] : '0;
  assign cnt_o   = cnt_q;

  // Next-state pointers and occupancy; simultaneous push and pop leave cnt alone.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop_s) begin
      head_d = ptr3_next(head_q);
    end else begin
      head_d = head_q;
    end
    if (push_i) begin
      tail_d = ptr3_next(tail_q);
    end else begin
      tail_d = tail_q;
    end
    case ({push_i, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= 2'd0;
      tail_q <= 2'd0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage; contents need no reset because data_o is masked while empty.
  always_ff @(posedge clk) begin
    if (push_i && !rst) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_adapter
// Drains the synchronous FIFO read port into a valid/ready stream, prefetching
// into a 3-entry buffer so one word per cycle can be sustained. fifo_rd_en
// depends only on registers, fifo_empty and rst -- never on m_ready.
// Optional feature macro: ADAPTER_STATS_EN (adds xfer_count).
// Ports:
//   clk, rst      : clock, synchronous active-high reset (shared with FIFO)
//   fifo_empty    : FIFO empty flag
//   fifo_rd_data  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    : read request to FIFO
//   m_valid       : output word available
//   m_ready       : consumer accepts word
//   m_data        : output word
//   xfer_count    : completed transfers, wraps (ADAPTER_STATS_EN only)
// -----------------------------------------------------------------------------
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef ADAPTER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  xfer_count
`endif
);

  if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("fifo_rd_stream_adapter: DATA_WIDTH and CNT_WIDTH must be positive");
  end

  logic       inflight_q, inflight_d;
  logic [1:0] buf_cnt_s;
  logic [2:0] occupancy_s;
  logic       rd_en_s;
  logic       pop_s;

  assign pop_s      = m_valid && m_ready;
  assign fifo_rd_en = rd_en_s;
  assign inflight_d = rd_en_s;

  // Issue rule: request only if the word (plus any still in flight) will fit.
  // Gating with rst keeps a read from being issued while the FIFO is resetting.
  always_comb begin
    occupancy_s = {1'b0, buf_cnt_s} + {2'b00, inflight_q};
    if (rst) begin
      rd_en_s = 1'b0;
    end else if (fifo_empty) begin
      rd_en_s = 1'b0;
    end else begin
      rd_en_s = (occupancy_s < 3'(ADAPTER_BUF_DEPTH));
    end
  end

  // inflight marks that fifo_rd_data carries a fresh word this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_skid_buf3 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_rd_data),
    .pop_i       (pop_s),
    .valid_o     (m_valid),
    .data_o      (m_data),
    .cnt_o       (buf_cnt_s)
  );

`ifdef ADAPTER_STATS_EN
  logic [CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;

  // Transfer counter next state; wraps naturally at 2^CNT_WIDTH.
  always_comb begin
    if (pop_s) begin
      xfer_count_d = xfer_count_q + CNT_WIDTH'(1);
    end else begin
      xfer_count_d = xfer_count_q;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream_adapter
// Self-checking bench: a queue-based FIFO model feeds the adapter; a scoreboard
// of written words checks delivery order, occupancy and stall stability, and a
// directed sequence checks reset, latency, streaming, backpressure and resets.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream_adapter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
`ifdef ADAPTER_STATS_EN
  logic [15:0] xfer_count;
`endif

  // FIFO model and scoreboard state
  logic       fq_empty = 1'b1;
  logic       hold     = 1'b0;
  logic       wr_en    = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         fifo_reads = 0;
  int         issued     = 0;
  int         delivered  = 0;
  int         n_pass     = 0;
  int         n_total    = 0;
  int         r0         = 0;
  int         written    = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always #5 clk = ~clk;

  // hold masks the FIFO contents so it can be pre-filled before draining
  assign fifo_empty = fq_empty | hold;

  fifo_rd_stream_adapter #(
    .DATA_WIDTH (8),
    .CNT_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data)
`ifdef ADAPTER_STATS_EN
    ,
    .xfer_count   (xfer_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Behavioural FIFO: registered read data, empty flag from its occupancy.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      exp_q.delete();
      fifo_rd_data <= 8'h00;
      fq_empty     <= 1'b1;
    end else begin
      if (fifo_rd_en && fq.size() > 0) begin
        fifo_rd_data <= fq.pop_front();
        fifo_reads++;
      end
      if (wr_en) begin
        fq.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
      fq_empty <= (fq.size() == 0);
    end
  end

  // Stream monitor: ordering, occupancy bound, stall stability.
  always @(negedge clk) begin
    if (rst) begin
      issued     = 0;
      delivered  = 0;
      prev_stall = 1'b0;
    end else begin
      if (fifo_rd_en) chk("rden_while_empty", fifo_empty, 0);
      chk("occupancy_le3", (issued - delivered) <= 3, 1);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        chk("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("order", m_data, exp_q.pop_front());
        delivered++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (fifo_rd_en) issued++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset / idle
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("rst_rden", fifo_rd_en, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("idle_rden", fifo_rd_en, 0);
      chk("idle_valid", m_valid, 0);
      chk("idle_data", m_data, 0);
      cyc();
    end

    // Latency: single word into an empty FIFO
    m_ready = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA5;
    cyc();
    wr_en = 1'b0;
    smp();
    chk("lat_empty_T", fifo_empty, 0);
    chk("lat_rden_T", fifo_rd_en, 1);
    chk("lat_valid_T", m_valid, 0);
    cyc(); smp();
    chk("lat_rden_T1", fifo_rd_en, 0);
    chk("lat_valid_T1", m_valid, 0);
    cyc(); smp();
    chk("lat_valid_T2", m_valid, 1);
    chk("lat_data_T2", m_data, 8'hA5);
    cyc(); smp();
    chk("lat_valid_T3", m_valid, 0);
    cyc();

    // Streaming from a pre-filled FIFO
    hold = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      cyc();
    end
    wr_en = 1'b0;
    hold  = 1'b0;
    smp();
    chk("stream_rden_T", fifo_rd_en, 1);
    cyc(); cyc(); smp();
    for (int i = 1; i <= 8; i++) begin
      chk("stream_valid", m_valid, 1);
      chk("stream_data", m_data, i);
      cyc(); smp();
    end
    chk("stream_end_valid", m_valid, 0);
    cyc();

    // Backpressure: buffer fills to 3, FIFO keeps the rest
    m_ready = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      cyc();
    end
    wr_en = 1'b0;
    r0    = fifo_reads;
    hold  = 1'b0;
    repeat (6) cyc();
    smp();
    chk("bp_reads", fifo_reads - r0, 3);
    chk("bp_fifo_cnt", fq.size(), 5);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 8'h10);
    cyc();
    m_ready = 1'b1;
    smp();
    for (int i = 0; i < 8; i++) begin
      chk("bp_drain_valid", m_valid, 1);
      chk("bp_drain_data", m_data, 8'h10 + 8'(i));
      cyc(); smp();
    end
    chk("bp_end_valid", m_valid, 0);
    cyc();

    // Reset while a read would otherwise issue
    m_ready = 1'b0;
    hold = 1'b1;
    wr_en = 1'b1; wr_data = 8'h55; cyc();
    wr_en = 1'b1; wr_data = 8'h66; cyc();
    wr_en = 1'b0;
    hold  = 1'b0;
    rst   = 1'b1;
    smp();
    chk("rst_read_ignored", fifo_rd_en, 0);
    cyc();
    rst = 1'b0;
    smp();
    chk("rst2_valid", m_valid, 0);
    chk("rst2_rden", fifo_rd_en, 0);
    cyc();

    // Random ready / random writes, 64 words
    written = 0;
    for (int c = 0; c < 3000 && delivered < 64; c++) begin
      wr_en   = (written < 64) && ($urandom_range(0, 3) != 0);
      wr_data = 8'($urandom);
      if (wr_en) written++;
      m_ready = ($urandom_range(0, 1) == 1);
      cyc();
    end
    wr_en   = 1'b0;
    m_ready = 1'b0;
    smp();
    chk("rand_written", written, 64);
    chk("rand_delivered", delivered, 64);
    chk("rand_scoreboard_empty", exp_q.size(), 0);
`ifdef ADAPTER_STATS_EN
    chk("rand_xfer_count", xfer_count, 64);
`endif
    cyc();

    // Reset mid-stream with cnt=2 and one read in flight
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
      cyc();
    end
    wr_en = 1'b0;
    hold  = 1'b0;
    smp(); chk("ms_rden_T", fifo_rd_en, 1);
    cyc(); smp(); chk("ms_rden_T1", fifo_rd_en, 1);
    cyc(); smp(); chk("ms_rden_T2", fifo_rd_en, 1);
    chk("ms_valid_T2", m_valid, 1);
    cyc();
    rst = 1'b1;
    smp();
    chk("ms_rden_rst", fifo_rd_en, 0);
    cyc();
    rst = 1'b0;
    smp();
    chk("ms_valid_after", m_valid, 0);
    chk("ms_data_after", m_data, 0);
`ifdef ADAPTER_STATS_EN
    chk("ms_xfer_after", xfer_count, 0);
`endif
    wr_en = 1'b1; wr_data = 8'h3C; m_ready = 1'b1;
    cyc();
    wr_en = 1'b0;
    smp();
    for (int i = 0; i < 10 && !m_valid; i++) begin
      cyc(); smp();
    end
    chk("ms_first_valid", m_valid, 1);
    chk("ms_first_word", m_data, 8'h3C);
    cyc(); smp();
    chk("ms_no_leftover", m_valid, 0);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
- Downstream stage of the counter-based synchronous FIFO.
- Converts the FIFO read side into a valid/ready stream. FIFO read side: rd_en/empty in, registered rd_data one cycle after an accepted read.
- Prefetches words into a 3-entry output buffer so the stream sustains 1 word/cycle. No combinational path from m_ready to fifo_rd_en.
- Shares clk/rst with the FIFO it drains.

Parameters:
- DATA_WIDTH, 8, width of each data word; must match the FIFO's DATA_WIDTH.
- CNT_WIDTH, 16, width of the transfer counter (used only with ADAPTER_STATS_EN).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DATA_WIDTH  FIFO registered read data; valid the cycle after an accepted fifo_rd_en.
- fifo_rd_en  output  1  read request to FIFO.
- m_valid  output  1  output word available.
- m_ready  input  1  consumer accepts word.
- m_data  output  DATA_WIDTH  output word.
- xfer_count  output  CNT_WIDTH  completed transfers; present only with ADAPTER_STATS_EN.

Behaviour:
- State registers:
  - buf[0:2] of DATA_WIDTH.
  - head, tail: 2-bit, wrap 2 -> 0 (not power of two; explicit wrap).
  - cnt: 2-bit, 0..3.
  - inflight: 1 bit, equal to fifo_rd_en of the previous cycle.
- Reset values: head=tail=cnt=0, inflight=0, fifo_rd_en=0, m_valid=0, m_data=0, xfer_count=0.
- Issue rule (combinational from registers and fifo_empty only): fifo_rd_en = !fifo_empty && (cnt + inflight) < 3.
- fifo_rd_en is never asserted while fifo_empty=1, so every request is accepted by the FIFO.
- Capture: when inflight=1, fifo_rd_data is written to buf[tail]; tail advances; cnt increments.
- Pop: when m_valid && m_ready, head advances and cnt decrements.
- Capture and pop in the same cycle: cnt unchanged; both pointers advance.
- m_valid = (cnt != 0). m_data = buf[head], or 0 when cnt=0.
- m_valid is never deasserted before acceptance, and m_data is stable while m_valid && !m_ready.
- Latency: FIFO goes non-empty in cycle T, fifo_rd_en=1 in T, data captured at end of T+1, m_valid=1 in T+2.
- Throughput: with m_ready held high and FIFO non-empty, steady state is cnt=1, inflight=1, with one word issued and one delivered per cycle.
- Backpressure: with m_ready=0, reads stop once cnt+inflight=3. The buffer then fills to exactly 3 and never overflows.
- Ordering: words leave in FIFO order; no drop, no duplicate.
- Reset mid-operation:
  - All buffered and in-flight words are discarded. FIFO pointers reset in the same cycle (shared rst).
  - A read issued in the cycle rst is asserted is ignored.
  - The first post-reset fifo_rd_en occurs no earlier than the first cycle with rst=0.

Optional Feature:
- Macro: ADAPTER_STATS_EN.
- Defined:
  - Adds port xfer_count.
  - xfer_count increments by 1 on every m_valid && m_ready cycle and wraps modulo 2^CNT_WIDTH.
  - Reset to 0 by rst.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_WIDTH default;
  - localparam ADAPTER_BUF_DEPTH=3;
  - typedef data_t (logic [DATA_WIDTH-1:0]);
  - typedef ptr3_t (logic [1:0]).
- One natural sub-module: fifo_skid_buf3. It holds the 3-entry buffer, head/tail/cnt and the push/pop interface.
- The top level holds the issue rule, the inflight register and the optional stats counter.

Test Plan:
- Reset/idle: hold rst 3 cycles with FIFO empty -> fifo_rd_en=0, m_valid=0, m_data=0 throughout and after release.
- Latency: write 0xA5 into the empty FIFO, m_ready=1 -> fifo_rd_en high the cycle empty drops; m_valid=1 with m_data=0xA5 two cycles later for exactly one cycle.
- Streaming: FIFO pre-filled with 0x01..0x08, m_ready=1 -> m_data delivers 0x01..0x08 on 8 consecutive cycles with m_valid continuously high.
- Backpressure: FIFO holds 0x10..0x17, m_ready=0 -> exactly 3 FIFO reads, FIFO count drops 8 -> 5, m_data=0x10 stable. Then raise m_ready -> 0x10..0x17 delivered in order with no gaps after the first.
- Random ready: m_ready toggles pseudo-randomly over 64 words -> scoreboard matches FIFO order with no loss/duplication; cnt never exceeds 3. With ADAPTER_STATS_EN, xfer_count ends at 64.
- Reset mid-stream: assert rst while cnt=2 and inflight=1 -> next cycle m_valid=0, xfer_count=0. The subsequent write of 0x3C emerges as the first post-reset word.
